deser_frame_arbiter: RTL

- Round-robin scheduler that shares one serial-to-parallel deserializer among N_REQ independent val/rdy word streams.
- Grants the deserializer's receive interface to one requester for one full frame of exactly N_SAMPLES words, then holds off the next grant until downstream reports the frame consumed.
- Publishes the owning source id so the parallel frame can be tagged.
- Sits directly upstream of the deserializer; frame_done is driven from the deserializer's send-side handshake (send_val and send_rdy).

---
 rtl/deser_frame_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/deser_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : deser_frame_arbiter
// Brief    : Round-robin frame-granular arbiter sharing one deserializer
//            among N_REQ val/rdy word streams, tagging each frame with its id.
// Revision : 1.0 - initial release
// ============================================================================
module deser_frame_arbiter #(
    parameter int N_REQ     = 4,
    parameter int N_SAMPLES = 8,
    parameter int BIT_WIDTH = 32,
    parameter int ID_W      = $clog2(N_REQ),
    parameter int CNT_W     = $clog2(N_SAMPLES)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_val,
    output logic [N_REQ-1:0]           req_rdy,
    input  logic [N_REQ*BIT_WIDTH-1:0] req_msg,
    output logic                       deser_val,
    input  logic                       deser_rdy,
    output logic [BIT_WIDTH-1:0]       deser_msg,
    input  logic                       frame_done,
    output logic                       grant_val,
    output logic [ID_W-1:0]            grant_id,
    output logic [CNT_W-1:0]           word_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [BIT_WIDTH-1:0] w_words [N_REQ];
    logic                 w_found;
    logic [ID_W-1:0]      w_sel;
    logic [ID_W:0]        w_sum;

    for (genvar i = 0; i < N_REQ; i++) begin : g_words
        assign w_words[i] = req_msg[i*BIT_WIDTH +: BIT_WIDTH];
    end

    // Scan from the farthest offset down so the nearest requester to rr_q wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, rr_q} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(N_REQ)) begin
                w_sum = w_sum - (ID_W+1)'(N_REQ);
            end
            if (req_val[w_sum[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        req_rdy   = '0;
        deser_val = 1'b0;
        deser_msg = w_words[grant_q];
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    grant_d = w_sel;
                    rr_d    = (w_sel == ID_W'(N_REQ - 1)) ? '0 : w_sel + ID_W'(1);
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                deser_val         = req_val[grant_q];
                req_rdy[grant_q]  = deser_rdy;
                if (req_val[grant_q] && deser_rdy) begin
                    if (cnt_q == CNT_W'(N_SAMPLES - 1)) begin
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (frame_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_val = (state_q != S_IDLE);
    assign grant_id  = grant_q;
    assign word_cnt  = cnt_q;

endmodule
`default_nettype wire
